// File: rtl/sysid_regs.sv
// Avalon-MM system-identification slave: build ID and timestamp, a 64-bit uptime counter
// with an atomic high-word snapshot, a control register and a bank of scratch registers.
module sysid_regs #(
    parameter logic [31:0] ID_VALUE     = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter int          ADDR_WIDTH   = 3,
    parameter int          NUM_SCRATCH  = 2,
    parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
    parameter int          UPTIME_DIV   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic [31:0]           readdata,
    output logic                  readdatavalid,
    output logic                  tick
);

    localparam int SCR_BASE  = 5;
    localparam int SCR_SLOTS = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

    // Bus handshake: there is no waitrequest, so read and write are accepted in their strobe
    // cycle. A read returns readdata with readdatavalid high for exactly one cycle on the next
    // edge. A read that coincides with a write is dropped and the write is performed.

    logic [63:0] uptime;
    logic [31:0] presc;
    logic [31:0] shadow_hi;
    logic        freeze;
    logic [31:0] scratch [SCR_SLOTS];

    logic [31:0] addr_w;
    logic        rd_en;
    logic        ctrl_wr;
    logic        clear_req;
    logic        presc_wrap;
    logic        incr;
    logic [31:0] rd_mux;

    assign addr_w     = 32'(address);
    assign rd_en      = read & ~write;
    assign ctrl_wr    = write && (addr_w == 32'd4);
    assign clear_req  = ctrl_wr & byteenable[0] & writedata[1];
    assign presc_wrap = (presc == 32'(UPTIME_DIV - 1));
    // Clear wins over an increment landing on the same edge, so no tick is produced either.
    assign incr       = ~freeze & presc_wrap & ~clear_req;

    always_comb begin
        rd_mux = 32'h0000_0000;
        case (addr_w)
            32'd0: rd_mux = ID_VALUE;
            32'd1: rd_mux = TIMESTAMP;
            32'd2: rd_mux = uptime[31:0];
            32'd3: rd_mux = shadow_hi;
            32'd4: rd_mux = {16'(NUM_SCRATCH), 15'd0, freeze};
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++) begin
                    if (addr_w == 32'(SCR_BASE + i)) begin
                        rd_mux = scratch[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            readdata      <= 32'h0000_0000;
            readdatavalid <= 1'b0;
            tick          <= 1'b0;
            uptime        <= 64'd0;
            presc         <= 32'd0;
            shadow_hi     <= 32'h0000_0000;
            freeze        <= 1'b0;
        end else begin
            tick          <= incr;
            readdatavalid <= rd_en;
            if (rd_en) begin
                readdata <= rd_mux;
            end
            // Snapshot taken from the same pre-edge value that supplies the low word.
            if (rd_en && (addr_w == 32'd2)) begin
                shadow_hi <= uptime[63:32];
            end
            if (clear_req) begin
                uptime <= 64'd0;
                presc  <= 32'd0;
            end else if (!freeze) begin
                if (presc_wrap) begin
                    presc  <= 32'd0;
                    uptime <= uptime + 64'd1;
                end else begin
                    presc <= presc + 32'd1;
                end
            end
            if (ctrl_wr && byteenable[0]) begin
                freeze <= writedata[0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SCR_SLOTS; i++) begin
                scratch[i] <= SCRATCH_INIT;
            end
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (write && (addr_w == 32'(SCR_BASE + i))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byteenable[b]) begin
                            scratch[i][8*b +: 8] <= writedata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sysid_regs.sv
// Bench for sysid_regs: two instances (uptime divider 4 and 1) share one bus and are
// compared against a cycle-count reference model and fixed expectations.
module tb_sysid_regs;

    localparam logic [31:0] ID_V   = 32'h1234_ABCD;
    localparam logic [31:0] TS_V   = 32'h5339_4D37;
    localparam logic [31:0] S_INIT = 32'h5A5A_0F0F;
    localparam int          DIV_A  = 4;
    localparam int          DIV_B  = 1;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [2:0]  address = 3'd0;
    logic [31:0] writedata = 32'h0;
    logic [3:0]  byteenable = 4'h0;
    logic [31:0] rdata_a, rdata_b;
    logic        rv_a, rv_b, tick_a, tick_b;

    int errors = 0;
    int checks = 0;

    sysid_regs #(
        .ID_VALUE(ID_V), .TIMESTAMP(TS_V), .ADDR_WIDTH(3), .NUM_SCRATCH(2),
        .SCRATCH_INIT(S_INIT), .UPTIME_DIV(DIV_A)
    ) dut_a (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rdata_a),
        .readdatavalid(rv_a), .tick(tick_a)
    );

    sysid_regs #(
        .ID_VALUE(ID_V), .TIMESTAMP(TS_V), .ADDR_WIDTH(3), .NUM_SCRATCH(2),
        .SCRATCH_INIT(S_INIT), .UPTIME_DIV(DIV_B)
    ) dut_b (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .readdata(rdata_b),
        .readdatavalid(rv_b), .tick(tick_b)
    );

    // Reference model: uptime is the number of unfrozen cycles since the last clear,
    // divided by the tick divisor.
    logic [63:0] act;
    logic        m_freeze;
    logic [31:0] m_shadow_a, m_shadow_b;
    logic [31:0] m_scr [2];
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];

    function automatic logic [31:0] model_read(input logic [2:0] a, input logic [63:0] up,
                                               input logic [31:0] sh);
        case (a)
            3'd0: return ID_V;
            3'd1: return TS_V;
            3'd2: return up[31:0];
            3'd3: return sh;
            3'd4: return {16'd2, 15'd0, m_freeze};
            3'd5: return m_scr[0];
            3'd6: return m_scr[1];
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        logic [63:0] up_a;
        act = 64'd0; m_freeze = 1'b0; m_shadow_a = 32'h0; m_shadow_b = 32'h0;
        m_scr[0] = S_INIT; m_scr[1] = S_INIT;
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                act = 64'd0; m_freeze = 1'b0; m_shadow_a = 32'h0; m_shadow_b = 32'h0;
                m_scr[0] = S_INIT; m_scr[1] = S_INIT;
                exp_a.delete(); exp_b.delete();
            end else begin
                up_a = act / DIV_A;
                if (read && !write) begin
                    exp_a.push_back(model_read(address, up_a, m_shadow_a));
                    exp_b.push_back(model_read(address, act / DIV_B, m_shadow_b));
                    if (address == 3'd2) begin
                        m_shadow_a = up_a[63:32];
                        m_shadow_b = act[63:32];
                    end
                end
                if (write && address == 3'd4 && byteenable[0] && writedata[1]) act = 64'd0;
                else if (!m_freeze) act = act + 64'd1;
                if (write && address == 3'd4 && byteenable[0]) m_freeze = writedata[0];
                if (write && (address == 3'd5 || address == 3'd6)) begin
                    for (int b = 0; b < 4; b++)
                        if (byteenable[b]) m_scr[address - 3'd5][8*b +: 8] = writedata[8*b +: 8];
                end
            end
        end
    end

    // driver tasks
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1; read = 1'b0; write = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clock);
        write = 1'b1; read = 1'b0; address = a; writedata = d; byteenable = be;
        @(negedge clock);
        write = 1'b0;
    endtask

    // Issues one read, checks the one-cycle valid pulse and scores data against the model.
    task automatic do_read(input logic [2:0] a, output logic [31:0] got_a, output logic [31:0] got_b);
        logic [31:0] ea, eb;
        @(negedge clock);
        read = 1'b1; write = 1'b0; address = a;
        @(negedge clock);
        read = 1'b0;
        got_a = rdata_a; got_b = rdata_b;
        checks++;
        if (rv_a !== 1'b1 || rv_b !== 1'b1) begin
            errors++;
            $display("FAIL rd_valid addr=%0d got a=%b b=%b want 1", a, rv_a, rv_b);
        end
        checks++;
        if (exp_a.size() == 0 || exp_b.size() == 0) begin
            errors++;
            $display("FAIL rd_queue addr=%0d model produced no entry", a);
        end else begin
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            if (got_a !== ea || got_b !== eb) begin
                errors++;
                $display("FAIL rd_data addr=%0d got a=%h b=%h want a=%h b=%h", a, got_a, got_b, ea, eb);
            end
        end
        @(negedge clock);
        checks++;
        if (rv_a !== 1'b0 || rv_b !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_width addr=%0d got a=%b b=%b want 0", a, rv_a, rv_b);
        end
    endtask

    task automatic test_reset();
        logic [31:0] ga, gb;
        #2;
        checks++;
        if (rdata_a !== 32'h0 || rv_a !== 1'b0 || tick_a !== 1'b0 ||
            rdata_b !== 32'h0 || rv_b !== 1'b0 || tick_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%h/%h rv=%b/%b tick=%b/%b want zeros",
                     rdata_a, rdata_b, rv_a, rv_b, tick_a, tick_b);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        do_read(3'd0, ga, gb);
        checks++;
        if (ga !== 32'h1234_ABCD) begin errors++; $display("FAIL id got %h want 1234abcd", ga); end
        do_read(3'd1, ga, gb);
        checks++;
        if (ga !== 32'h5339_4D37) begin errors++; $display("FAIL timestamp got %h want 53394d37", ga); end
        do_read(3'd4, ga, gb);
        checks++;
        if (ga !== 32'h0002_0000) begin errors++; $display("FAIL ctrl_reset got %h want 00020000", ga); end
        do_read(3'd6, ga, gb);
        checks++;
        if (gb !== S_INIT) begin errors++; $display("FAIL scratch_init got %h want %h", gb, S_INIT); end
    endtask

    task automatic test_prescaler();
        int ticks_a, ticks_b, last, first;
        logic [31:0] ga, gb;
        ticks_a = 0; ticks_b = 0; last = -1; first = -1;
        apply_reset();
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (tick_a) begin
                if (first < 0) first = k;
                if (last >= 0) begin
                    checks++;
                    if (k - last != DIV_A) begin
                        errors++;
                        $display("FAIL tick_spacing got %0d want %0d", k - last, DIV_A);
                    end
                end
                last = k;
                ticks_a++;
            end
            if (tick_b) ticks_b++;
        end
        checks++;
        if (ticks_a != 10 || first != 4) begin
            errors++;
            $display("FAIL tick_count_div4 got %0d (first %0d) want 10 (first 4)", ticks_a, first);
        end
        checks++;
        if (ticks_b != 40) begin errors++; $display("FAIL tick_count_div1 got %0d want 40", ticks_b); end
        do_read(3'd2, ga, gb);
        checks++;
        if (ga !== 32'd10) begin errors++; $display("FAIL uptime_div4 got %0d want 10", ga); end
    endtask

    task automatic test_snapshot();
        logic [31:0] lo_a, lo_b, hi_a, hi_b;
        do_write(3'd4, 32'h2, 4'hF);
        repeat ($urandom_range(3, 12)) @(negedge clock);
        do_read(3'd2, lo_a, lo_b);
        checks++;
        if (lo_b == 32'h0) begin errors++; $display("FAIL snapshot_low got %h want nonzero", lo_b); end
        repeat ($urandom_range(2, 6)) @(negedge clock);
        do_read(3'd3, hi_a, hi_b);
        checks++;
        if (hi_a !== 32'h0 || hi_b !== 32'h0) begin
            errors++;
            $display("FAIL snapshot_high got %h/%h want 0", hi_a, hi_b);
        end
    endtask

    task automatic test_freeze();
        logic [31:0] a1, b1, a2, b2;
        do_write(3'd4, 32'h1, 4'b1110);
        do_read(3'd4, a1, b1);
        checks++;
        if (a1 !== 32'h0002_0000) begin errors++; $display("FAIL ctrl_be0_masked got %h want 00020000", a1); end
        do_write(3'd4, 32'h1, 4'hF);
        do_read(3'd2, a1, b1);
        repeat (20) @(negedge clock);
        do_read(3'd2, a2, b2);
        checks++;
        if (a1 !== a2 || b1 !== b2) begin
            errors++;
            $display("FAIL freeze_hold got %h/%h want %h/%h", a2, b2, a1, b1);
        end
        do_write(3'd4, 32'h3, 4'hF);
        do_read(3'd2, a1, b1);
        checks++;
        if (a1 !== 32'h0 || b1 !== 32'h0) begin errors++; $display("FAIL clear_frozen got %h/%h want 0", a1, b1); end
        do_read(3'd4, a1, b1);
        checks++;
        if (a1 !== 32'h0002_0001) begin errors++; $display("FAIL ctrl_read got %h want 00020001", a1); end
        do_write(3'd4, 32'h0, 4'hF);
        repeat (9) @(negedge clock);
        do_read(3'd2, a1, b1);
    endtask

    task automatic test_scratch();
        logic [31:0] ga, gb;
        do_write(3'd5, 32'hDEAD_BEEF, 4'hF);
        do_write(3'd5, 32'h0000_0011, 4'b0001);
        do_read(3'd5, ga, gb);
        checks++;
        if (ga !== 32'hDEAD_BE11) begin errors++; $display("FAIL scratch_be got %h want deadbe11", ga); end
        do_write(3'd7, 32'hFFFF_FFFF, 4'hF);
        do_read(3'd7, ga, gb);
        checks++;
        if (ga !== 32'h0) begin errors++; $display("FAIL unmapped got %h want 0", ga); end
        do_write(3'd0, 32'h0BAD_F00D, 4'hF);
        do_read(3'd0, ga, gb);
        checks++;
        if (ga !== ID_V) begin errors++; $display("FAIL id_readonly got %h want %h", ga, ID_V); end
    endtask

    task automatic test_rw_collision();
        logic [31:0] d, ga, gb;
        d = $urandom;
        @(negedge clock);
        read = 1'b1; write = 1'b1; address = 3'd6; writedata = d; byteenable = 4'hF;
        @(negedge clock);
        read = 1'b0; write = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rv_a !== 1'b0 || rv_b !== 1'b0) begin
                errors++;
                $display("FAIL rw_collision_valid got %b/%b want 0", rv_a, rv_b);
            end
            @(negedge clock);
        end
        do_read(3'd6, ga, gb);
        checks++;
        if (ga !== d) begin errors++; $display("FAIL rw_collision_write got %h want %h", ga, d); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] addrs [4];
        logic [31:0] ea, eb;
        for (int i = 0; i < 4; i++) addrs[i] = 3'($urandom_range(0, 7));
        for (int i = 0; i <= 4; i++) begin
            @(negedge clock);
            if (i > 0) begin
                checks++;
                if (rv_a !== 1'b1 || rv_b !== 1'b1 || exp_a.size() == 0 || exp_b.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_valid idx=%0d got %b/%b want 1", i - 1, rv_a, rv_b);
                end else begin
                    ea = exp_a.pop_front(); eb = exp_b.pop_front();
                    if (rdata_a !== ea || rdata_b !== eb) begin
                        errors++;
                        $display("FAIL b2b_data addr=%0d got %h/%h want %h/%h",
                                 addrs[i-1], rdata_a, rdata_b, ea, eb);
                    end
                end
            end
            if (i < 4) begin read = 1'b1; address = addrs[i]; end
            else read = 1'b0;
        end
        @(negedge clock);
        checks++;
        if (rv_a !== 1'b0 || rv_b !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b/%b want 0", rv_a, rv_b); end
    endtask

    task automatic test_random();
        logic [31:0] ga, gb;
        logic [2:0]  a;
        int          op;
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 2);
            a  = 3'($urandom_range(0, 7));
            case (op)
                0: do_write(a, $urandom, 4'($urandom_range(0, 15)));
                1: do_read(a, ga, gb);
                default: @(negedge clock);
            endcase
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] ga, gb;
        do_write(3'd5, 32'h1111_2222, 4'hF);
        @(negedge clock);
        read = 1'b1; address = 3'd5;
        @(posedge clock);
        #1;
        reset = 1'b1; read = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (rv_a !== 1'b0 || rv_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_valid got %b/%b want 0", rv_a, rv_b);
            end
        end
        reset = 1'b0;
        do_read(3'd5, ga, gb);
        checks++;
        if (ga !== S_INIT) begin errors++; $display("FAIL reset_mid_scratch got %h want %h", ga, S_INIT); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_prescaler();
        test_snapshot();
        test_freeze();
        test_scratch();
        test_rw_collision();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
